// File: rtl/system_spi_slave.sv
// system_spi_slave: SPI responder (CPOL=1, CPHA=1, MSB first, single select)
// with the same CPU register port as the system SPI master.
// Optional end-of-packet detection is enabled by defining SPI_SLAVE_EOP_EN.
module system_spi_slave #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata,
  output logic        endofpacket,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS_n,
  output logic        MISO,
  output logic        MISO_oe
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
`ifdef SPI_SLAVE_EOP_EN
  localparam logic [15:0] CTRL_MASK = 16'h03D8;
`else
  localparam logic [15:0] CTRL_MASK = 16'h01D8;
`endif

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, mosi_sync, ssn_sync;
  logic                    sclk_d, ssn_d;
  logic                    sclk_s, mosi_s, ssn_s;
  logic                    sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [DATA_WIDTH-1:0]   shift_reg, tx_holding, rx_holding, rx_byte;
  logic [CW-1:0]           bitcnt;
  logic                    primed, rrdy, roe, toe, eop;
  logic [15:0]             control, status_word, rd_data;
`ifdef SPI_SLAVE_EOP_EN
  logic [15:0]             eop_value;
`endif
  logic                    acc_busy, acc_strobe, acc_go, rd_go, wr_go;
  logic                    wr_tx, wr_status, wr_ctrl, rd_rx;

  // Input synchronisers plus one extra stage for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ssn_sync  <= '0;
      sclk_d    <= 1'b0;
      ssn_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], SS_n};
      sclk_d    <= sclk_s;
      ssn_d     <= ssn_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ssn_s     = ssn_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ssn_s & ssn_d;
  assign ss_rise   = ssn_s & ~ssn_d;
  assign rx_byte   = {shift_reg[DATA_WIDTH-2:0], mosi_s};

  // One access per strobe; acc_busy blocks re-triggering while it is held
  assign acc_strobe = spi_select & (~read_n | ~write_n);
  assign acc_go     = acc_strobe & ~acc_busy;
  assign rd_go      = acc_go & ~read_n;
  assign wr_go      = acc_go & ~write_n;
  assign wr_tx      = wr_go && (mem_addr == 3'd1);
  assign wr_status  = wr_go && (mem_addr == 3'd2);
  assign wr_ctrl    = wr_go && (mem_addr == 3'd3);
  assign rd_rx      = rd_go && (mem_addr == 3'd0);

  assign status_word = {6'b0, eop, roe | toe, rrdy, ~primed,
                        ~primed & (state == ST_IDLE), toe, roe, 3'b0};
  assign dataavailable = rrdy;
  assign readyfordata  = ~primed;
  assign endofpacket   = eop;

  // Register read multiplexer
  always_comb begin
    rd_data = '0;
    case (mem_addr)
      3'd0: rd_data = 16'(rx_holding);
      3'd2: rd_data = status_word;
      3'd3: rd_data = control;
`ifdef SPI_SLAVE_EOP_EN
      3'd6: rd_data = eop_value;
`endif
      default: rd_data = '0;
    endcase
  end

  // CPU register port: read data, control, eop value and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_busy    <= 1'b0;
      data_to_cpu <= '0;
      control     <= '0;
      irq         <= 1'b0;
`ifdef SPI_SLAVE_EOP_EN
      eop_value   <= '0;
`endif
    end else begin
      acc_busy <= acc_strobe;
      irq      <= |(status_word & control);
      if (rd_go)   data_to_cpu <= rd_data;
      if (wr_ctrl) control     <= data_from_cpu & CTRL_MASK;
`ifdef SPI_SLAVE_EOP_EN
      if (wr_go && (mem_addr == 3'd6)) eop_value <= data_from_cpu;
`endif
    end
  end

  // Datapath FSM with TX/RX holding registers and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      bitcnt     <= '0;
      MISO       <= 1'b0;
      MISO_oe    <= 1'b0;
      tx_holding <= '0;
      primed     <= 1'b0;
      rx_holding <= '0;
      rrdy       <= 1'b0;
      roe        <= 1'b0;
      toe        <= 1'b0;
      eop        <= 1'b0;
    end else begin
      // CPU clears come first so that hardware sets later in the block win
      if (rd_rx) rrdy <= 1'b0;
      if (wr_status) begin
        rrdy <= 1'b0;
        roe  <= 1'b0;
        toe  <= 1'b0;
        eop  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          MISO_oe <= 1'b0;
          bitcnt  <= '0;
          if (ss_fall) begin
            state   <= ST_SHIFT;
            MISO_oe <= 1'b1;
            if (primed) begin
              shift_reg <= tx_holding;
              MISO      <= tx_holding[DATA_WIDTH-1];
              primed    <= 1'b0;
            end else begin
              shift_reg <= '0;
              MISO      <= 1'b0;
            end
          end
        end
        ST_SHIFT: begin
          if (ss_rise) begin
            state   <= ST_IDLE;
            MISO_oe <= 1'b0;
            bitcnt  <= '0;
          end else if (sclk_rise) begin
            if (bitcnt == LAST_BIT) begin
              rx_holding <= rx_byte;
              rrdy       <= 1'b1;
              if (rrdy) roe <= 1'b1;
              bitcnt     <= '0;
`ifdef SPI_SLAVE_EOP_EN
              if (rx_byte == eop_value[DATA_WIDTH-1:0]) eop <= 1'b1;
`endif
              if (primed) begin
                shift_reg <= tx_holding;
                primed    <= 1'b0;
              end else begin
                shift_reg <= '0;
              end
            end else begin
              shift_reg <= rx_byte;
              bitcnt    <= bitcnt + CW'(1);
            end
          end else if (sclk_fall) begin
            MISO <= shift_reg[DATA_WIDTH-1];
          end
        end
        default: state <= ST_IDLE;
      endcase
      // TX write sees the pre-reload primed flag: a same-cycle reload of a
      // primed holding register makes this write an overrun
      if (wr_tx) begin
        if (!primed) begin
          tx_holding <= data_from_cpu[DATA_WIDTH-1:0];
          primed     <= 1'b1;
        end else begin
          toe <= 1'b1;
        end
`ifdef SPI_SLAVE_EOP_EN
        if (data_from_cpu[DATA_WIDTH-1:0] == eop_value[DATA_WIDTH-1:0]) eop <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_system_spi_slave.sv
// Testbench for system_spi_slave: SPI master model plus CPU bus tasks,
// checked against a flag-level reference model of the slave.
module tb_system_spi_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_select = 1'b0;
  logic [2:0]  mem_addr = '0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [15:0] data_from_cpu = '0;
  logic [15:0] data_to_cpu;
  logic        irq, dataavailable, readyfordata, endofpacket;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        SS_n = 1'b1;
  logic        MISO, MISO_oe;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SPI_SLAVE_EOP_EN
  localparam bit EOP_EN = 1'b1;
`else
  localparam bit EOP_EN = 1'b0;
`endif

  system_spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
    .readyfordata(readyfordata), .endofpacket(endofpacket),
    .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO), .MISO_oe(MISO_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  bit          m_primed, m_rrdy, m_roe, m_toe, m_eop, m_busy;
  logic [7:0]  m_hold, m_rx, m_cur;
  logic [15:0] m_ctrl, m_eopval;

  function automatic void m_reset();
    m_primed = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_eop = 0; m_busy = 0;
    m_hold = 0; m_rx = 0; m_cur = 0; m_ctrl = 0; m_eopval = 0;
  endfunction

  function automatic logic [15:0] m_status();
    int s = 0;
    if (m_eop)            s += 512;
    if (m_roe || m_toe)   s += 256;
    if (m_rrdy)           s += 128;
    if (!m_primed)        s += 64;
    if (!m_primed && !m_busy) s += 32;
    if (m_toe)            s += 16;
    if (m_roe)            s += 8;
    return 16'(s);
  endfunction

  function automatic bit m_irq();
    return (m_status() & m_ctrl) != 16'h0;
  endfunction

  // byte the slave shifts out next: the primed holding value, else zero
  function automatic logic [7:0] m_take_tx();
    if (m_primed) begin
      m_primed = 0;
      return m_hold;
    end
    return 8'h00;
  endfunction

  function automatic void m_cpu_tx(input logic [7:0] d);
    if (EOP_EN && d == m_eopval[7:0]) m_eop = 1;
    if (!m_primed) begin
      m_hold = d; m_primed = 1;
    end else m_toe = 1;
  endfunction

  function automatic void m_rx_byte(input logic [7:0] b);
    if (m_rrdy) m_roe = 1;
    m_rrdy = 1;
    m_rx = b;
    if (EOP_EN && b == m_eopval[7:0]) m_eop = 1;
    m_cur = m_take_tx();
  endfunction

  // ---------------- CPU bus ----------------
  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    spi_select = 1; mem_addr = a; write_n = 0; data_from_cpu = d;
    @(negedge clk);
    spi_select = 0; write_n = 1;
    case (a)
      3'd1: m_cpu_tx(d[7:0]);
      3'd2: begin m_rrdy = 0; m_roe = 0; m_toe = 0; m_eop = 0; end
      3'd3: m_ctrl = d & (EOP_EN ? 16'h03D8 : 16'h01D8);
      3'd6: if (EOP_EN) m_eopval = d;
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    spi_select = 1; mem_addr = a; read_n = 0;
    @(negedge clk);
    spi_select = 0; read_n = 1;
    d = data_to_cpu;
    if (a == 3'd0) m_rrdy = 0;
  endtask

  // ---------------- SPI master (SCLK = clk/16) ----------------
  task automatic spi_start();
    @(negedge clk);
    SS_n = 0;
    m_busy = 1;
    m_cur = m_take_tx();
    repeat (8) @(negedge clk);
    n_tests++;
    if (MISO_oe !== 1'b1) begin
      n_fail++; $display("FAIL miso_oe_sel: got %b expected 1", MISO_oe);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      SCLK = 0; MOSI = tx[7-i];
      repeat (8) @(negedge clk);
      SCLK = 1; rx[7-i] = MISO;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    logic [7:0] got, exp;
    exp = m_cur;
    spi_bits(tx, 8, got);
    m_rx_byte(tx);
    n_tests++;
    if (got !== exp) begin
      n_fail++; $display("FAIL miso_byte: got %h expected %h", got, exp);
    end
  endtask

  task automatic spi_stop();
    @(negedge clk);
    SS_n = 1;
    m_busy = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_status(input string nm);
    logic [15:0] r;
    bus_read(3'd2, r);
    n_tests++;
    if (r !== m_status()) begin
      n_fail++; $display("FAIL %s: got %h expected %h", nm, r, m_status());
    end
  endtask

  task automatic chk_rx(input string nm);
    logic [15:0] r, e;
    e = {8'h00, m_rx};
    bus_read(3'd0, r);
    n_tests++;
    if (r !== e) begin
      n_fail++; $display("FAIL %s: got %h expected %h", nm, r, e);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    m_reset();
    reset_n = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({data_to_cpu, irq, MISO, MISO_oe, dataavailable, readyfordata, endofpacket} !== {16'h0, 6'b000010}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%b%b%b%b%b%b expected 0000/000010",
               data_to_cpu, irq, MISO, MISO_oe, dataavailable, readyfordata, endofpacket);
    end
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk_status("reset_status");
  endtask

  task automatic test_single();
    bus_write(3'd1, 16'h00A5);
    spi_start();
    chk_status("single_trdy_after_sel");
    spi_byte(8'h3C);
    spi_stop();
    n_tests++;
    if (dataavailable !== 1'b1) begin
      n_fail++; $display("FAIL single_rrdy: got %b expected 1", dataavailable);
    end
    chk_status("single_status");
    chk_rx("single_rxdata");
  endtask

  task automatic test_back_to_back();
    bus_write(3'd1, 16'h005A);
    spi_start();
    spi_byte(8'h11);
    spi_byte(8'h22);
    spi_stop();
    chk_status("b2b_roe");
    chk_rx("b2b_rxdata");
    bus_write(3'd2, 16'h0000);
    chk_status("b2b_cleared");
  endtask

  task automatic test_abort();
    logic [7:0] got;
    spi_start();
    spi_bits(8'hE7, 5, got);
    spi_stop();
    n_tests++;
    if (dataavailable !== 1'b0) begin
      n_fail++; $display("FAIL abort_rrdy: got %b expected 0", dataavailable);
    end
    spi_start();
    spi_byte(8'h81);
    spi_stop();
    chk_rx("abort_next_rx");
  endtask

  task automatic test_overrun();
    bit prev;
    bus_write(3'd2, 16'h0000);
    bus_write(3'd3, 16'h0010);
    bus_write(3'd1, 16'h003E);
    prev = m_irq();
    bus_write(3'd1, 16'h00C7);
    n_tests++;
    if (irq !== prev) begin
      n_fail++; $display("FAIL toe_irq_latency: got %b expected %b", irq, prev);
    end
    @(negedge clk);
    n_tests++;
    if (irq !== m_irq()) begin
      n_fail++; $display("FAIL toe_irq: got %b expected %b", irq, m_irq());
    end
    chk_status("toe_status");
    spi_start();
    spi_byte(8'h44);
    spi_stop();
    bus_write(3'd2, 16'h0000);
    bus_write(3'd3, 16'h0000);
    chk_status("toe_cleared");
  endtask

  task automatic test_eop();
    logic [15:0] r;
`ifdef SPI_SLAVE_EOP_EN
    bus_write(3'd6, 16'h000D);
    bus_read(3'd6, r);
    n_tests++;
    if (r !== 16'h000D) begin
      n_fail++; $display("FAIL eop_value_rb: got %h expected 000d", r);
    end
    bus_write(3'd3, 16'h0200);
    spi_start();
    spi_byte(8'h0D);
    spi_stop();
    n_tests++;
    if (endofpacket !== 1'b1) begin
      n_fail++; $display("FAIL eop_flag: got %b expected 1", endofpacket);
    end
    chk_status("eop_status");
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL eop_irq: got %b expected 1", irq);
    end
    bus_write(3'd2, 16'h0000);
    bus_write(3'd3, 16'h0000);
`else
    bus_write(3'd6, 16'h1234);
    bus_read(3'd6, r);
    n_tests++;
    if (r !== 16'h0000) begin
      n_fail++; $display("FAIL addr6_read: got %h expected 0000", r);
    end
    bus_write(3'd3, 16'h0200);
    bus_read(3'd3, r);
    n_tests++;
    if (r !== 16'h0000) begin
      n_fail++; $display("FAIL ctrl9_read: got %h expected 0000", r);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    bus_write(3'd1, 16'h0096);
    spi_start();
    spi_bits(8'hF0, 4, got);
    @(negedge clk);
    reset_n = 0;
    m_reset();
    @(negedge clk);
    n_tests++;
    if ({MISO_oe, MISO} !== 2'b00) begin
      n_fail++; $display("FAIL midreset_miso: got %b%b expected 00", MISO_oe, MISO);
    end
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk_status("midreset_status");
    spi_bits(8'hF0, 4, got);
    spi_stop();
    n_tests++;
    if (dataavailable !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ignored: got %b expected 0", dataavailable);
    end
    spi_start();
    spi_byte(8'h5B);
    spi_stop();
    chk_rx("midreset_next_rx");
  endtask

  task automatic test_random();
    logic [7:0]  got, exp, msk;
    logic [15:0] r;
    int          nb, n;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) bus_write(3'd1, 16'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) bus_write(3'd1, 16'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) bus_write(3'd3, 16'($urandom));
      spi_start();
      nb = $urandom_range(1, 2);
      for (int b = 0; b < nb; b++) begin
        if (b == nb - 1 && $urandom_range(0, 4) == 0) begin
          n = $urandom_range(1, 7);
          exp = m_cur;
          spi_bits(8'($urandom), n, got);
          msk = 8'hFF << (8 - n);
          n_tests++;
          if ((got & msk) !== (exp & msk)) begin
            n_fail++; $display("FAIL rand_partial: got %h expected %h", got & msk, exp & msk);
          end
        end else begin
          spi_byte(8'($urandom));
        end
      end
      spi_stop();
      chk_status("rand_status");
      n_tests++;
      if ({dataavailable, readyfordata, endofpacket, irq} !== {m_rrdy, !m_primed, m_eop, m_irq()}) begin
        n_fail++;
        $display("FAIL rand_flags: got %b%b%b%b expected %b%b%b%b",
                 dataavailable, readyfordata, endofpacket, irq, m_rrdy, !m_primed, m_eop, m_irq());
      end
      if ($urandom_range(0, 1) == 1) chk_rx("rand_rxdata");
      if ($urandom_range(0, 2) == 0) bus_write(3'd2, 16'h0000);
      if ($urandom_range(0, 3) == 0) begin
        bus_read(3'd3, r);
        n_tests++;
        if (r !== m_ctrl) begin
          n_fail++; $display("FAIL rand_ctrl: got %h expected %h", r, m_ctrl);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_eop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
